mips32_issue_scoreboard: RTL and testbench

Parametrised issue stage for the MIPS32 pipeline. It sits between decode and the execute stages and removes the need to hand-insert dummy instructions (e.g. 32'h0ce77800) into programs. A per-register countdown scoreboard detects RAW and WAW hazards and issues a bubble instruction instead of the dependent one. Producer latency is configurable, separately for ALU and load results, so the block supports both forwarding and non-forwarding pipeline builds. HALT is held back until the pipeline has drained.

---
 rtl/mips32_issue_scoreboard.sv | 96 +++++++++
 tb/tb_mips32_issue_scoreboard.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_issue_scoreboard.sv
// Issue stage with a per-register countdown scoreboard: stalls RAW/WAW-dependent
// instructions by emitting bubble words, and holds HALT until all counters drain.
module mips32_issue_scoreboard #(
    parameter int unsigned NREG         = 32,
    parameter int unsigned RADDR        = 5,
    parameter int unsigned ALU_LAT      = 3,
    parameter int unsigned LOAD_LAT     = 4,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0ce77800,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [RADDR-1:0] in_rs,
    input  logic [RADDR-1:0] in_rt,
    input  logic             in_use_rs,
    input  logic             in_use_rt,
    input  logic [RADDR-1:0] in_rd,
    input  logic             in_wr,
    input  logic             in_is_load,
    input  logic             in_halt,
    output logic             out_valid,
    output logic [31:0]      out_instr,
    output logic             out_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int unsigned CW       = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [CW-1:0] ALU_SET  = CW'(ALU_LAT - 1);
    localparam logic [CW-1:0] LOAD_SET = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt [NREG];
    logic          any_busy;
    logic          hazard;
    logic          accept;
    logic          stall;
    logic          set_en;

    always_comb begin
        any_busy = 1'b0;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (cnt[r] != '0) any_busy = 1'b1;
        end
    end

    always_comb begin
        hazard = 1'b0;
        if (in_use_rs && in_rs != '0 && cnt[in_rs] != '0) hazard = 1'b1;
        if (in_use_rt && in_rt != '0 && cnt[in_rt] != '0) hazard = 1'b1;
        if (in_wr && in_rd != '0 && cnt[in_rd] != '0)     hazard = 1'b1;
        if (in_halt && any_busy)                           hazard = 1'b1;
    end

    assign in_ready = in_valid && !hazard && !halted;
    assign accept   = in_ready;
    assign stall    = in_valid && !in_ready && !halted;
    assign set_en   = accept && in_wr && (in_rd != '0);

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
            out_valid  <= 1'b0;
            out_bubble <= 1'b0;
            out_instr  <= BUBBLE_INSTR;
            halted     <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            // A fresh producer reload takes priority over the per-cycle countdown.
            for (int unsigned r = 0; r < NREG; r++) begin
                if (set_en && in_rd == RADDR'(r))
                    cnt[r] <= in_is_load ? LOAD_SET : ALU_SET;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_ONE;
            end

            if (accept) begin
                out_valid  <= 1'b1;
                out_bubble <= 1'b0;
                out_instr  <= in_instr;
                if (in_halt) halted <= 1'b1;
            end else if (stall) begin
                out_valid  <= 1'b1;
                out_bubble <= 1'b1;
                out_instr  <= BUBBLE_INSTR;
                if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
                out_valid  <= 1'b0;
                out_bubble <= 1'b0;
                out_instr  <= BUBBLE_INSTR;
            end
        end
    end
endmodule

// File: tb/tb_mips32_issue_scoreboard.sv
// Bench for mips32_issue_scoreboard: three parameterisations checked every cycle
// against a ready-time reference model, plus a cycle table and directed sequences.
module tb_mips32_issue_scoreboard;
    localparam logic [31:0] BUB = 32'h0ce77800;
    localparam int ND = 3;

    localparam logic [31:0] W_ADDI1 = 32'h2001000a;
    localparam logic [31:0] W_ADDI2 = 32'h20020014;
    localparam logic [31:0] W_ADDI3 = 32'h20030019;
    localparam logic [31:0] W_ADD4  = 32'h00222020;
    localparam logic [31:0] W_ADD5  = 32'h00832820;
    localparam logic [31:0] W_HALT  = 32'hfc000000;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [4:0]  rs, rt, rd;
        logic        use_rs, use_rt, wr, is_load, halt;
    } ins_t;

    typedef struct packed {
        ins_t        ins;
        logic        ev, eb;
        logic [31:0] ei;
        logic        eh;
    } vec_t;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        rst_n      [ND];
    ins_t        cur        [ND];
    logic        in_ready   [ND];
    logic        out_valid  [ND];
    logic [31:0] out_instr  [ND];
    logic        out_bubble [ND];
    logic        halted     [ND];
    logic [15:0] st0, st1;
    logic [3:0]  st2;

    mips32_issue_scoreboard u_def (
        .clk1(clk1), .rst_n(rst_n[0]), .in_valid(cur[0].valid), .in_ready(in_ready[0]),
        .in_instr(cur[0].instr), .in_rs(cur[0].rs), .in_rt(cur[0].rt),
        .in_use_rs(cur[0].use_rs), .in_use_rt(cur[0].use_rt), .in_rd(cur[0].rd),
        .in_wr(cur[0].wr), .in_is_load(cur[0].is_load), .in_halt(cur[0].halt),
        .out_valid(out_valid[0]), .out_instr(out_instr[0]), .out_bubble(out_bubble[0]),
        .halted(halted[0]), .stall_cnt(st0));

    mips32_issue_scoreboard #(.ALU_LAT(1)) u_fwd (
        .clk1(clk1), .rst_n(rst_n[1]), .in_valid(cur[1].valid), .in_ready(in_ready[1]),
        .in_instr(cur[1].instr), .in_rs(cur[1].rs), .in_rt(cur[1].rt),
        .in_use_rs(cur[1].use_rs), .in_use_rt(cur[1].use_rt), .in_rd(cur[1].rd),
        .in_wr(cur[1].wr), .in_is_load(cur[1].is_load), .in_halt(cur[1].halt),
        .out_valid(out_valid[1]), .out_instr(out_instr[1]), .out_bubble(out_bubble[1]),
        .halted(halted[1]), .stall_cnt(st1));

    mips32_issue_scoreboard #(.CNT_W(4)) u_sat (
        .clk1(clk1), .rst_n(rst_n[2]), .in_valid(cur[2].valid), .in_ready(in_ready[2]),
        .in_instr(cur[2].instr), .in_rs(cur[2].rs), .in_rt(cur[2].rt),
        .in_use_rs(cur[2].use_rs), .in_use_rt(cur[2].use_rt), .in_rd(cur[2].rd),
        .in_wr(cur[2].wr), .in_is_load(cur[2].is_load), .in_halt(cur[2].halt),
        .out_valid(out_valid[2]), .out_instr(out_instr[2]), .out_bubble(out_bubble[2]),
        .halted(halted[2]), .stall_cnt(st2));

    // Reference model: a register is busy until the cycle its result may be consumed.
    int unsigned cyc = 0;
    int unsigned rdy_at  [ND][32];
    bit          m_halt  [ND];
    int unsigned m_stall [ND];
    bit          e_valid [ND];
    bit          e_bub   [ND];
    logic [31:0] e_instr [ND];
    bit          dut_rdy [ND];
    int unsigned alat [ND] = '{3, 1, 3};
    int unsigned llat [ND] = '{4, 4, 4};
    int unsigned cmax [ND] = '{65535, 65535, 15};

    int tests = 0;
    int fails = 0;

    ins_t prog [6];
    vec_t tbl  [11];

    function automatic logic [31:0] stall_of(int d);
        if (d == 0) return {16'b0, st0};
        if (d == 1) return {16'b0, st1};
        return {28'b0, st2};
    endfunction

    function automatic ins_t mk(logic [31:0] w, logic [4:0] rs, bit urs, logic [4:0] rt,
                                bit urt, logic [4:0] rd, bit wr, bit ld, bit hlt);
        ins_t x;
        x.valid = 1'b1; x.instr = w; x.rs = rs; x.rt = rt; x.rd = rd;
        x.use_rs = urs; x.use_rt = urt; x.wr = wr; x.is_load = ld; x.halt = hlt;
        return x;
    endfunction

    function automatic vec_t row(ins_t x, bit ev, bit eb, logic [31:0] ei, bit eh);
        vec_t v;
        v.ins = x; v.ev = ev; v.eb = eb; v.ei = ei; v.eh = eh;
        return v;
    endfunction

    function automatic bit busy(int d, logic [4:0] r);
        return (r != 5'd0) && (rdy_at[d][r] > cyc);
    endfunction

    function automatic bit model_ready(int d);
        bit hz = 1'b0;
        if (cur[d].use_rs && busy(d, cur[d].rs)) hz = 1'b1;
        if (cur[d].use_rt && busy(d, cur[d].rt)) hz = 1'b1;
        if (cur[d].wr && busy(d, cur[d].rd))     hz = 1'b1;
        if (cur[d].halt)
            for (int r = 1; r < 32; r++) if (busy(d, 5'(r))) hz = 1'b1;
        return cur[d].valid && !hz && !m_halt[d];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(int d, bit acc);
        if (!rst_n[d]) begin
            for (int r = 0; r < 32; r++) rdy_at[d][r] = 0;
            m_halt[d] = 0; m_stall[d] = 0;
            e_valid[d] = 0; e_bub[d] = 0; e_instr[d] = BUB;
        end else if (acc) begin
            e_valid[d] = 1; e_bub[d] = 0; e_instr[d] = cur[d].instr;
            if (cur[d].wr && cur[d].rd != 5'd0)
                rdy_at[d][cur[d].rd] = cyc + (cur[d].is_load ? llat[d] : alat[d]);
            if (cur[d].halt) m_halt[d] = 1;
        end else if (cur[d].valid && !m_halt[d]) begin
            e_valid[d] = 1; e_bub[d] = 1; e_instr[d] = BUB;
            if (m_stall[d] < cmax[d]) m_stall[d]++;
        end else begin
            e_valid[d] = 0; e_bub[d] = 0; e_instr[d] = BUB;
        end
    endtask

    task automatic tick();
        bit rdy [ND];
        @(negedge clk1);
        for (int d = 0; d < ND; d++) begin
            rdy[d] = model_ready(d);
            dut_rdy[d] = in_ready[d];
            check($sformatf("d%0d in_ready", d), {31'b0, in_ready[d]}, {31'b0, rdy[d]});
        end
        for (int d = 0; d < ND; d++) model_update(d, rdy[d]);
        cyc++;
        @(posedge clk1);
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d out_valid", d), {31'b0, out_valid[d]}, {31'b0, e_valid[d]});
            check($sformatf("d%0d out_bubble", d), {31'b0, out_bubble[d]}, {31'b0, e_bub[d]});
            check($sformatf("d%0d out_instr", d), out_instr[d], e_instr[d]);
            check($sformatf("d%0d halted", d), {31'b0, halted[d]}, {31'b0, m_halt[d]});
            check($sformatf("d%0d stall_cnt", d), stall_of(d), m_stall[d]);
        end
    endtask

    task automatic do_reset(int d);
        cur[d] = '0;
        rst_n[d] = 1'b0;
        tick();
        rst_n[d] = 1'b1;
    endtask

    // Present x and hold it until the DUT issues it; count bubbles seen meanwhile.
    task automatic push(int d, ins_t x, output int bub);
        bit done = 1'b0;
        bub = 0;
        cur[d] = x;
        for (int k = 0; k < 16 && !done; k++) begin
            tick();
            if (out_valid[d] && !out_bubble[d]) done = 1'b1;
            else if (out_bubble[d]) bub++;
        end
        check($sformatf("d%0d push_issued", d), {31'b0, done}, 32'd1);
        cur[d] = '0;
    endtask

    function automatic ins_t rand_ins();
        ins_t x;
        x.valid   = ($urandom % 5) != 0;
        x.instr   = $urandom;
        x.rs      = 5'($urandom_range(0, 7));
        x.rt      = 5'($urandom_range(0, 7));
        x.rd      = 5'($urandom_range(0, 7));
        x.use_rs  = 1'($urandom);
        x.use_rt  = 1'($urandom);
        x.wr      = 1'($urandom);
        x.is_load = ($urandom % 3) == 0;
        x.halt    = 1'b0;
        return x;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, tot;
        prog[0] = mk(W_ADDI1, 5'd0, 1, 5'd0, 0, 5'd1, 1, 0, 0);
        prog[1] = mk(W_ADDI2, 5'd0, 1, 5'd0, 0, 5'd2, 1, 0, 0);
        prog[2] = mk(W_ADDI3, 5'd0, 1, 5'd0, 0, 5'd3, 1, 0, 0);
        prog[3] = mk(W_ADD4,  5'd1, 1, 5'd2, 1, 5'd4, 1, 0, 0);
        prog[4] = mk(W_ADD5,  5'd4, 1, 5'd3, 1, 5'd5, 1, 0, 0);
        prog[5] = mk(W_HALT,  5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);

        tbl[0]  = row(prog[0], 1, 0, W_ADDI1, 0);
        tbl[1]  = row(prog[1], 1, 0, W_ADDI2, 0);
        tbl[2]  = row(prog[2], 1, 0, W_ADDI3, 0);
        tbl[3]  = row(prog[3], 1, 1, BUB,     0);
        tbl[4]  = row(prog[3], 1, 0, W_ADD4,  0);
        tbl[5]  = row(prog[4], 1, 1, BUB,     0);
        tbl[6]  = row(prog[4], 1, 1, BUB,     0);
        tbl[7]  = row(prog[4], 1, 0, W_ADD5,  0);
        tbl[8]  = row(prog[5], 1, 1, BUB,     0);
        tbl[9]  = row(prog[5], 1, 1, BUB,     0);
        tbl[10] = row(prog[5], 1, 0, W_HALT,  1);

        for (int d = 0; d < ND; d++) begin
            cur[d] = '0;
            rst_n[d] = 1'b0;
        end
        tick();
        for (int d = 0; d < ND; d++) begin
            rst_n[d] = 1'b1;
            check($sformatf("d%0d reset out_instr", d), out_instr[d], BUB);
            check($sformatf("d%0d reset out_valid", d), {31'b0, out_valid[d]}, 32'd0);
            check($sformatf("d%0d reset stall", d), stall_of(d), 32'd0);
        end

        // Dependent ALU stream with default latencies, cycle by cycle
        for (int i = 0; i < 11; i++) begin
            cur[0] = tbl[i].ins;
            tick();
            check($sformatf("t1 row%0d valid", i), {31'b0, out_valid[0]}, {31'b0, tbl[i].ev});
            check($sformatf("t1 row%0d bubble", i), {31'b0, out_bubble[0]}, {31'b0, tbl[i].eb});
            check($sformatf("t1 row%0d instr", i), out_instr[0], tbl[i].ei);
            check($sformatf("t1 row%0d halted", i), {31'b0, halted[0]}, {31'b0, tbl[i].eh});
        end
        check("t1 stall_cnt", stall_of(0), 32'd5);
        cur[0] = prog[0];
        tick();
        check("t1 post-halt ready", {31'b0, dut_rdy[0]}, 32'd0);
        check("t1 post-halt valid", {31'b0, out_valid[0]}, 32'd0);
        check("t1 post-halt halted", {31'b0, halted[0]}, 32'd1);

        // Full forwarding: same stream, no bubbles
        tot = 0;
        for (int i = 0; i < 6; i++) begin
            push(1, prog[i], b);
            tot += b;
        end
        check("t2 bubbles", tot, 32'd0);
        check("t2 stall_cnt", stall_of(1), 32'd0);
        check("t2 halted", {31'b0, halted[1]}, 32'd1);

        // Load-use distance
        do_reset(0);
        push(0, mk(32'h8c060000, 5'd0, 1, 5'd0, 0, 5'd6, 1, 1, 0), b);
        check("t3 load bubbles", b, 32'd0);
        push(0, mk(32'h00c13820, 5'd6, 1, 5'd1, 1, 5'd7, 1, 0, 0), b);
        check("t3 load-use bubbles", b, 32'd3);

        // WAW on a load destination, then R0 writer/reader never stall
        push(0, mk(32'h8c080000, 5'd0, 1, 5'd0, 0, 5'd8, 1, 1, 0), b);
        push(0, mk(32'h20080001, 5'd0, 1, 5'd0, 0, 5'd8, 1, 0, 0), b);
        check("t4 waw bubbles", b, 32'd3);
        push(0, mk(32'h20000005, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0), b);
        check("t4 r0 write bubbles", b, 32'd0);
        push(0, mk(32'h00004820, 5'd0, 1, 5'd0, 1, 5'd9, 1, 0, 0), b);
        check("t4 r0 read bubbles", b, 32'd0);

        // Reset in the middle of the ADD R5 bubbles
        do_reset(0);
        for (int i = 0; i < 6; i++) begin
            cur[0] = tbl[i].ins;
            tick();
        end
        check("t5 pre-reset bubble", {31'b0, out_bubble[0]}, 32'd1);
        cur[0] = prog[4];
        rst_n[0] = 1'b0;
        tick();
        rst_n[0] = 1'b1;
        check("t5 reset valid", {31'b0, out_valid[0]}, 32'd0);
        check("t5 reset stall", stall_of(0), 32'd0);
        tick();
        check("t5 add5 instr", out_instr[0], W_ADD5);
        check("t5 add5 bubble", {31'b0, out_bubble[0]}, 32'd0);
        cur[0] = '0;

        // Saturation with a 4-bit stall counter
        do_reset(2);
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            push(2, mk(32'h8c090000, 5'd0, 1, 5'd0, 0, 5'd9, 1, 1, 0), b);
            tot += b;
        end
        check("t6 total bubbles", tot, 32'd21);
        check("t6 stall saturated", stall_of(2), 32'd15);

        // Randomized traffic on all instances against the model
        for (int d = 0; d < ND; d++) do_reset(d);
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < ND; d++)
                if (!(cur[d].valid && !dut_rdy[d])) cur[d] = rand_ins();
            tick();
        end
        for (int d = 0; d < ND; d++) cur[d] = '0;
        for (int d = 0; d < ND; d++) begin
            push(d, prog[5], b);
            check($sformatf("d%0d final halted", d), {31'b0, halted[d]}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
